// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO seven-segment scanner.
package gpio_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned IDX_W      = 3;

  typedef enum logic {
    SLOT_DEAD  = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_state_e;

  // One displayable frame: hex codes, decimal points and per-digit blanking.
  typedef struct packed {
    logic [NUM_DIGITS*DIGIT_W-1:0] digits;
    logic [NUM_DIGITS-1:0]         dp;
    logic [NUM_DIGITS-1:0]         blank;
  } disp_frame_t;

  // Active-low {g,f,e,d,c,b,a} patterns, entry k decodes hex code k.
  localparam logic [15:0][SEG_W-1:0] SSEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex code to active-low seven-segment pattern decoder.
module hex_to_sseg
  import gpio_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [SEG_W-1:0]   seg_n_c
);

  assign seg_n_c = SSEG_TABLE[code];

endmodule

// File: rtl/gpio_sseg_scan.sv
// Eight-digit multiplexed seven-segment driver with frame-aligned updates
// and per-slot anode dead time.
module gpio_sseg_scan
  import gpio_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY_HZ       = 50_000_000,
  parameter int unsigned REFRESH_FREQUENCY_HZ   = 1000,
  parameter int unsigned DEAD_CYCLES            = 4,
  parameter int unsigned CNTR_WIDTH             = 32,
  parameter int unsigned SIMULATE               = 0,
  parameter int unsigned SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_in,
  input  logic                          load,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [SEG_W-1:0]              seg_n,
  output logic                          dp_n,
  output logic                          load_ack,
  output logic                          frame_done
);

  localparam int unsigned TOP = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                                : (CLK_FREQUENCY_HZ / REFRESH_FREQUENCY_HZ) - 1;
  localparam logic [CNTR_WIDTH-1:0] TOP_C = CNTR_WIDTH'(TOP);
  localparam int unsigned DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNTR_WIDTH-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  slot_state_e           state_q, state_d;
  logic [DEAD_W-1:0]     dead_q, dead_d;
  disp_frame_t           stage_q, stage_d;
  disp_frame_t           shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [SEG_W-1:0]      seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;
  logic                  load_ack_q, load_ack_d;
  logic                  frame_done_q, frame_done_d;

  disp_frame_t           frame_in;
  logic                  tick;
  logic                  wrap;
  logic                  lit;
  logic [DIGIT_W-1:0]    cur_code;
  logic [SEG_W-1:0]      cur_seg_c;

  assign cur_code = shadow_q.digits[{idx_q, 2'b00} +: DIGIT_W];

  hex_to_sseg u_hex_to_sseg (
    .code    (cur_code),
    .seg_n_c (cur_seg_c)
  );

  // Prescaler, slot sequencing, load handshake and pin encoding.
  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    state_d      = state_q;
    dead_d       = dead_q;
    stage_d      = stage_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    an_n_d       = '1;
    seg_n_d      = '1;
    dp_n_d       = 1'b1;
    load_ack_d   = 1'b0;
    frame_done_d = 1'b0;

    frame_in.digits = digits_in;
    frame_in.dp     = dp_in;
    frame_in.blank  = blank_in;

    tick    = (presc_q == TOP_C);
    wrap    = tick && (idx_q == IDX_LAST);
    presc_d = tick ? '0 : presc_q + CNTR_WIDTH'(1);

    if (tick) begin
      idx_d   = idx_q + IDX_W'(1);
      dead_d  = '0;
      state_d = (DEAD_CYCLES == 0) ? SLOT_DRIVE : SLOT_DEAD;
    end else begin
      case (state_q)
        SLOT_DEAD: begin
          if ((DEAD_CYCLES == 0) || (dead_q == DEAD_LAST)) begin
            state_d = SLOT_DRIVE;
          end else begin
            dead_d = dead_q + DEAD_W'(1);
          end
        end
        SLOT_DRIVE: state_d = SLOT_DRIVE;
        default:    state_d = SLOT_DEAD;
      endcase
    end

    // A load landing on the wrap edge bypasses staging so it is never lost.
    if (wrap && load) begin
      shadow_d  = frame_in;
      pending_d = 1'b0;
    end else if (wrap && pending_q) begin
      shadow_d  = stage_q;
      pending_d = 1'b0;
    end else if (load) begin
      stage_d   = frame_in;
      pending_d = 1'b1;
    end
    load_ack_d   = wrap && (pending_q || load);
    frame_done_d = wrap;

    lit = (state_q == SLOT_DRIVE) && !shadow_q.blank[idx_q];
    if (lit) begin
      an_n_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_n_d = cur_seg_c;
      dp_n_d  = ~shadow_q.dp[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q          <= '0;
      idx_q            <= '0;
      state_q          <= SLOT_DEAD;
      dead_q           <= '0;
      stage_q.digits   <= '0;
      stage_q.dp       <= '0;
      stage_q.blank    <= '1;
      shadow_q.digits  <= '0;
      shadow_q.dp      <= '0;
      shadow_q.blank   <= '1;
      pending_q        <= 1'b0;
      an_n_q           <= '1;
      seg_n_q          <= '1;
      dp_n_q           <= 1'b1;
      load_ack_q       <= 1'b0;
      frame_done_q     <= 1'b0;
    end else begin
      presc_q          <= presc_d;
      idx_q            <= idx_d;
      state_q          <= state_d;
      dead_q           <= dead_d;
      stage_q          <= stage_d;
      shadow_q         <= shadow_d;
      pending_q        <= pending_d;
      an_n_q           <= an_n_d;
      seg_n_q          <= seg_n_d;
      dp_n_q           <= dp_n_d;
      load_ack_q       <= load_ack_d;
      frame_done_q     <= frame_done_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gpio_sseg_scan.sv
// Bench for gpio_sseg_scan: time-based display model plus directed and random loads.
module tb_gpio_sseg_scan;

  localparam int SLOT  = 6;
  localparam int DEAD  = 2;
  localparam int FRAME = 8 * SLOT;
  localparam int BOUND = 200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blank_in = '0;
  logic        load = 1'b0;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        load_ack;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  gpio_sseg_scan #(
    .CLK_FREQUENCY_HZ       (50_000_000),
    .REFRESH_FREQUENCY_HZ   (1000),
    .DEAD_CYCLES            (2),
    .CNTR_WIDTH             (32),
    .SIMULATE               (1),
    .SIMULATE_FREQUENCY_CNT (5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .load_ack   (load_ack),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec_of(input logic [3:0] c);
    case (c)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: slot position is pure arithmetic on clocks since reset release.
  int          n;
  bit          model_valid = 1'b0;
  logic [31:0] m_shd_dig, m_stg_dig;
  logic [7:0]  m_shd_dp, m_stg_dp, m_shd_blank, m_stg_blank;
  bit          m_pend;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_ack, e_fd;

  always @(posedge clk) begin
    int presc, idx;
    bit lit, wrap;
    model_valid = 1'b1;
    if (!reset_n) begin
      n = 0;
      m_shd_dig = '0; m_shd_dp = '0; m_shd_blank = 8'hFF;
      m_stg_dig = '0; m_stg_dp = '0; m_stg_blank = 8'hFF;
      m_pend = 1'b0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_ack = 1'b0; e_fd = 1'b0;
    end else begin
      presc = n % SLOT;
      idx   = (n / SLOT) % 8;
      lit   = (presc >= DEAD) && !m_shd_blank[idx];
      e_an  = lit ? ~(8'h01 << idx) : 8'hFF;
      e_seg = lit ? dec_of(m_shd_dig[idx*4 +: 4]) : 7'h7F;
      e_dp  = lit ? ~m_shd_dp[idx] : 1'b1;
      wrap  = (presc == SLOT - 1) && (idx == 7);
      e_ack = wrap && (m_pend || load);
      e_fd  = wrap;
      if (wrap && load) begin
        m_shd_dig = digits_in; m_shd_dp = dp_in; m_shd_blank = blank_in; m_pend = 1'b0;
      end else if (wrap && m_pend) begin
        m_shd_dig = m_stg_dig; m_shd_dp = m_stg_dp; m_shd_blank = m_stg_blank; m_pend = 1'b0;
      end else if (load) begin
        m_stg_dig = digits_in; m_stg_dp = dp_in; m_stg_blank = blank_in; m_pend = 1'b1;
      end
      n++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("an_n",       32'(an_n),       32'(e_an));
      check("seg_n",      32'(seg_n),      32'(e_seg));
      check("dp_n",       32'(dp_n),       32'(e_dp));
      check("load_ack",   32'(load_ack),   32'(e_ack));
      check("frame_done", 32'(frame_done), 32'(e_fd));
    end
  end

  task automatic wait_pulse(input bit want_ack, input string name);
    int  k;
    bit  seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < BOUND) begin
      @(negedge clk);
      k++;
      seen = want_ack ? (load_ack === 1'b1) : (frame_done === 1'b1);
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
    digits_in = d; dp_in = p; blank_in = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    digits_in = $urandom;
    dp_in = 8'($urandom);
    blank_in = 8'($urandom);
  endtask

  initial begin
    int cnt_a, cnt_b, cnt_c, cnt_d;
    bit after;

    // Reset held three clocks.
    repeat (3) @(negedge clk);
    check("rst_an_n",  32'(an_n),       32'hFF);
    check("rst_seg_n", 32'(seg_n),      32'h7F);
    check("rst_dp_n",  32'(dp_n),       32'd1);
    check("rst_ack",   32'(load_ack),   32'd0);
    check("rst_fd",    32'(frame_done), 32'd0);
    reset_n = 1'b1;

    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    repeat (2 * FRAME + 2) begin
      @(negedge clk);
      if (an_n !== 8'hFF) cnt_a++;
      if (frame_done === 1'b1) cnt_b++;
      if (load_ack === 1'b1) cnt_c++;
    end
    check("dark_lit_cycles", 32'(cnt_a), 32'd0);
    check("dark_frames",     32'(cnt_b), 32'd2);
    check("dark_acks",       32'(cnt_c), 32'd0);

    // Basic load and slot layout.
    do_load(32'h0123_ABCF, 8'h00, 8'h00);
    wait_pulse(1'b1, "ack_basic");
    cnt_a = 0;
    for (int s = 1; s <= SLOT; s++) begin
      @(negedge clk);
      if (an_n !== 8'hFF) cnt_a++;
      if (s == 1) check("slot0_dark", 32'(an_n), 32'hFF);
      if (s == 3) begin
        check("slot0_an",  32'(an_n),  32'hFE);
        check("slot0_seg", 32'(seg_n), 32'b0001110);
      end
    end
    check("slot0_lit_len", 32'(cnt_a), 32'd4);
    repeat (3 * SLOT + 2 + 1 - SLOT) @(negedge clk);
    check("slot3_an",  32'(an_n),  32'hF7);
    check("slot3_seg", 32'(seg_n), 32'b0001000);
    check("slot3_dp",  32'(dp_n),  32'd1);

    // Two loads inside one frame: last wins, single ack.
    wait_pulse(1'b0, "fd_before_two_loads");
    repeat (10) @(negedge clk);
    do_load(32'h1111_1111, 8'h00, 8'h00);
    repeat (10) @(negedge clk);
    do_load(32'h2222_2222, 8'h00, 8'h00);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; after = 1'b0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (load_ack === 1'b1) begin cnt_a++; after = 1'b1; end
      else if (after) begin
        if (seg_n === 7'b1111001) cnt_b++;
        if (an_n !== 8'hFF && seg_n !== 7'b0100100) cnt_c++;
        if (seg_n === 7'b0100100) cnt_d++;
      end
    end
    check("two_loads_acks",     32'(cnt_a), 32'd1);
    check("two_loads_no_1",     32'(cnt_b), 32'd0);
    check("two_loads_wrong",    32'(cnt_c), 32'd0);
    check("two_loads_shows_2",  32'(cnt_d > 0), 32'd1);

    // Load exactly on the wrap tick.
    wait_pulse(1'b0, "fd_before_wrap_load");
    repeat (FRAME - 1) @(negedge clk);
    do_load(32'h8888_8888, 8'h00, 8'h00);
    check("wrap_load_ack", 32'(load_ack),   32'd1);
    check("wrap_load_fd",  32'(frame_done), 32'd1);
    repeat (3) @(negedge clk);
    check("wrap_load_an",  32'(an_n),  32'hFE);
    check("wrap_load_seg", 32'(seg_n), 32'b0000000);

    // Blanked low digits with all decimal points set.
    do_load($urandom, 8'hFF, 8'h0F);
    wait_pulse(1'b1, "ack_blank");
    cnt_a = 0; cnt_b = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (an_n[3:0] !== 4'hF) cnt_a++;
      if (dp_n === 1'b0 && an_n === 8'hFF) cnt_a++;
      if (dp_n === 1'b0) cnt_b++;
    end
    check("blank_violations", 32'(cnt_a), 32'd0);
    check("blank_dp_cycles",  32'(cnt_b), 32'd16);

    // Reset in slot 5 with a load pending.
    repeat (2) @(negedge clk);
    do_load(32'h5A5A_5A5A, 8'hAA, 8'h00);
    repeat (31) @(negedge clk);
    check("pre_reset_slot5_lit", 32'(an_n), 32'hDF);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_an_n",  32'(an_n),       32'hFF);
    check("mid_rst_seg_n", 32'(seg_n),      32'h7F);
    check("mid_rst_dp_n",  32'(dp_n),       32'd1);
    check("mid_rst_ack",   32'(load_ack),   32'd0);
    check("mid_rst_fd",    32'(frame_done), 32'd0);
    reset_n = 1'b1;
    cnt_a = 0;
    repeat (2 * FRAME + 4) begin
      @(negedge clk);
      if (load_ack === 1'b1) cnt_a++;
    end
    check("no_ack_after_reset", 32'(cnt_a), 32'd0);

    // Random loads at random phases against the model.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 40)) @(negedge clk);
      do_load($urandom, 8'($urandom), 8'($urandom) & 8'($urandom));
    end
    repeat (2 * FRAME) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
